tc_pl_merge: RTL
================

TC_PL_MERGE -- requirements
Module: tc_pl_merge

Interface
REQ-001 SHALL have parameter ADC0_0, default 14, meaning ADC sample width.
REQ-002 SHALL have parameter ADC0_1, default 56, meaning merged word width; it SHALL equal 4*ADC0_0.
REQ-003 SHALL have parameter ADC0_2, default 2, meaning phase width.
REQ-004 SHALL have parameter LEN_W, default 16, meaning word-count width.
REQ-005 SHALL have parameter FIFO_AW, default 3, meaning output FIFO address width (depth 8).
REQ-006 SHALL have port clk125, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have ports Gc_adc_data (input, ADC0_0 bits, ADC sample) and Gc_adc_of (input, 1 bit, overrange).
REQ-009 SHALL have ports Gc_cap_trig (input, 1 bit, start request), Gc_cap_phase (input, ADC0_2 bits, leading samples to discard) and Gc_cap_len (input, LEN_W bits, words to produce).
REQ-010 SHALL have port Gc_capr_rdy, output, 1 bit: ready to accept a trigger.
REQ-011 SHALL have ports Gc_merge_data (output, ADC0_1 bits), Gc_mereg_datv (output, 1 bit, valid) and Gc_mereg_datr (input, 1 bit, ready).
REQ-012 SHALL have ports merge_done (output, 1 bit, one-cycle completion pulse), merge_of (output, 1 bit, sticky overrange) and merge_ovf (output, 1 bit, sticky FIFO overflow).

Function
REQ-013 SHALL implement states IDLE, SKIP, PACK and DRAIN.
REQ-014 In IDLE, Gc_capr_rdy SHALL be 1; in all other states it SHALL be 0.
REQ-015 At IDLE with Gc_cap_trig=1, on that edge the block SHALL latch phase and len, clear merge_of and merge_ovf, and go to SKIP (phase!=0), PACK (phase=0) or DRAIN (len=0).
REQ-016 Gc_cap_trig SHALL be ignored outside IDLE.
REQ-017 SKIP SHALL discard exactly phase samples, one per cycle, then enter PACK.
REQ-018 PACK SHALL capture one sample per cycle; the first sample of a word goes to bits [ADC0_0-1:0], and the fourth to the top lane.
REQ-019 A sample with Gc_adc_of=1 SHALL be stored as all-ones, and merge_of SHALL be set.
REQ-020 On the edge capturing the fourth sample, the word SHALL be pushed to the FIFO and the word counter incremented; Gc_mereg_datv SHALL rise on the following cycle.
REQ-021 If the FIFO is full at push time, the word SHALL be dropped, merge_ovf set, and the counter still incremented.
REQ-022 When the counter reaches len, the block SHALL enter DRAIN; sampling SHALL stop.
REQ-023 DRAIN SHALL wait for FIFO empty, then pulse merge_done for one cycle and return to IDLE on the same edge.
REQ-024 The FIFO SHALL be show-ahead: Gc_merge_data is the head word, Gc_mereg_datv = not empty, and a pop occurs on Gc_mereg_datv && Gc_mereg_datr.
REQ-025 On a simultaneous push and pop at full, both SHALL succeed, with no overflow.
REQ-026 Gc_merge_data SHALL hold steady while Gc_mereg_datv=1 and Gc_mereg_datr=0.
REQ-027 Counter arithmetic SHALL be unsigned LEN_W bits; len = 2^LEN_W-1 SHALL be supported without wrap.

Reset
REQ-028 rst=1 SHALL asynchronously force state IDLE and clear the FIFO pointers, lane index and word counter.
REQ-029 During rst, outputs SHALL be: Gc_capr_rdy=1, Gc_mereg_datv=0, Gc_merge_data=0, merge_done=0, merge_of=0, merge_ovf=0.
REQ-030 Reset mid-capture SHALL discard partial and buffered words, and no merge_done SHALL be issued.

Structure
REQ-031 Package tc_pl_pkg SHALL hold the state enum and the width constants ADC0_0, ADC0_1 and ADC0_2.
REQ-032 Sub-module tc_pl_merge_fifo SHALL implement the synchronous show-ahead FIFO with full/empty flags.

Verification
REQ-033 Scenario: phase=0, len=2, samples 1..8, datr=1 -> words 0x0004_0003_0002_0001 (lane-packed) then lanes 8,7,6,5, followed by one merge_done.
REQ-034 Scenario: phase=3, len=1, samples 1..7 -> single word with lanes 4,5,6,7, where sample 4 is in bits [13:0].
REQ-035 Scenario: datr=0, len=10 -> 8 words buffered, merge_ovf=1, and DRAIN waits until datr=1 empties the FIFO.
REQ-036 Scenario: Gc_adc_of=1 on the second sample -> lane1=0x3FFF and merge_of=1.
REQ-037 Scenario: trigger while in PACK -> ignored and the word count is unchanged; rst asserted mid-PACK -> datv=0 and capr_rdy=1 immediately.
REQ-038 Scenario: len=0 -> no words, and merge_done two cycles after the trigger.

Source files
------------

// File: rtl/tc_pl_pkg.sv
// tc_pl_pkg: shared widths and FSM state encoding for the ADC sample merger.
// Contents: ADC0_0 (sample width), ADC0_1 (merged word width), ADC0_2 (phase width), state_t.
package tc_pl_pkg;
   localparam int ADC0_0 = 14;
   localparam int ADC0_1 = 4 * ADC0_0;
   localparam int ADC0_2 = 2;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      PACK  = 2'd2,
      DRAIN = 2'd3
   } state_t;
endpackage

// File: rtl/tc_pl_merge_fifo.sv
// tc_pl_merge_fifo: synchronous show-ahead FIFO with full/empty flags.
// Ports: clk125/rst (async active-high), push/wdata (write side), rd_rdy (consumer ready),
//        rdata/valid (head word, not-empty), full, drop (push lost because full and no pop).
module tc_pl_merge_fifo #(
   parameter int W  = 56,
   parameter int AW = 3
) (
   input  logic         clk125,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         rd_rdy,
   output logic [W-1:0] rdata,
   output logic         valid,
   output logic         full,
   output logic         drop
);
   localparam int D = 1 << AW;
   logic [W-1:0] mem [D];
   logic [AW:0]  wp, rp;
   logic         empty, pop, wr;
   // Extra pointer bit distinguishes full from empty when the addresses match.
   assign empty = wp == rp;
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop   = !empty && rd_rdy;
   // A pop on the same edge frees the slot, so a push at full still lands.
   assign wr    = push && (!full || pop);
   assign drop  = push && full && !pop;
   assign valid = !empty;
   assign rdata = empty ? '0 : mem[rp[AW-1:0]];
   always_ff @(posedge clk125 or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr) wp <= wp + (AW+1)'(1);
         if (pop) rp <= rp + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk125) begin
      if (wr) mem[wp[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/tc_pl_merge.sv
// tc_pl_merge: packs four consecutive ADC samples into one word and streams words out.
// Ports: clk125, rst (async active-high); Gc_adc_data/Gc_adc_of (sample, overrange);
//        Gc_cap_trig/Gc_cap_phase/Gc_cap_len (capture request), Gc_capr_rdy (idle);
//        Gc_merge_data/Gc_mereg_datv/Gc_mereg_datr (show-ahead word stream);
//        merge_done (completion pulse), merge_of/merge_ovf (sticky overrange / FIFO overflow).
module tc_pl_merge #(
   parameter int ADC0_0  = 14,
   parameter int ADC0_1  = 56,
   parameter int ADC0_2  = 2,
   parameter int LEN_W   = 16,
   parameter int FIFO_AW = 3
) (
   input  logic              clk125,
   input  logic              rst,
   input  logic [ADC0_0-1:0] Gc_adc_data,
   input  logic              Gc_adc_of,
   input  logic              Gc_cap_trig,
   input  logic [ADC0_2-1:0] Gc_cap_phase,
   input  logic [LEN_W-1:0]  Gc_cap_len,
   output logic              Gc_capr_rdy,
   output logic [ADC0_1-1:0] Gc_merge_data,
   output logic              Gc_mereg_datv,
   input  logic              Gc_mereg_datr,
   output logic              merge_done,
   output logic              merge_of,
   output logic              merge_ovf
);
   import tc_pl_pkg::*;
   state_t              st;
   logic [ADC0_2-1:0]   skip_cnt;
   logic [LEN_W-1:0]    len_r, cnt, cnt_nxt;
   logic [1:0]          lane;
   logic [3*ADC0_0-1:0] acc;
   logic [ADC0_0-1:0]   samp;
   logic                push, full, drop;
   assign samp        = Gc_adc_of ? '1 : Gc_adc_data;
   assign push        = (st == PACK) && (lane == 2'd3);
   assign cnt_nxt     = cnt + LEN_W'(1);
   assign Gc_capr_rdy = st == IDLE;
   tc_pl_merge_fifo #(.W(ADC0_1), .AW(FIFO_AW)) u_fifo (
      .clk125 (clk125),
      .rst    (rst),
      .push   (push),
      .wdata  ({samp, acc}),
      .rd_rdy (Gc_mereg_datr),
      .rdata  (Gc_merge_data),
      .valid  (Gc_mereg_datv),
      .full   (full),
      .drop   (drop)
   );
   always_ff @(posedge clk125 or posedge rst) begin
      if (rst) begin
         st         <= IDLE;
         skip_cnt   <= '0;
         len_r      <= '0;
         cnt        <= '0;
         lane       <= '0;
         acc        <= '0;
         merge_done <= 1'b0;
         merge_of   <= 1'b0;
         merge_ovf  <= 1'b0;
      end else begin
         merge_done <= 1'b0;
         if (drop) merge_ovf <= 1'b1;
         case (st)
            IDLE: if (Gc_cap_trig) begin
               skip_cnt  <= Gc_cap_phase;
               len_r     <= Gc_cap_len;
               cnt       <= '0;
               lane      <= '0;
               merge_of  <= 1'b0;
               merge_ovf <= 1'b0;
               // A zero-length request skips sampling entirely, whatever the phase.
               st <= (Gc_cap_len == '0) ? DRAIN : (Gc_cap_phase != '0) ? SKIP : PACK;
            end
            SKIP: begin
               skip_cnt <= skip_cnt - ADC0_2'(1);
               if (skip_cnt == ADC0_2'(1)) st <= PACK;
            end
            PACK: begin
               lane <= lane + 2'd1;
               if (Gc_adc_of) merge_of <= 1'b1;
               // The fourth sample goes straight into the FIFO word, not into acc.
               if (lane != 2'd3) acc[lane*ADC0_0 +: ADC0_0] <= samp;
               else begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == len_r) st <= DRAIN;
               end
            end
            DRAIN: if (!Gc_mereg_datv) begin
               merge_done <= 1'b1;
               st         <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule
